// File: rtl/seq_shifter.sv
// Sequential multi-mode shifter: parallel load, then N 1-bit shift/rotate steps under a 3-state FSM.
// Latency: amount cycles busy plus one done cycle; no backpressure. Optional carry flop under SEQ_SHIFTER_CARRY_EN.
module seq_shifter #(
    parameter int N  = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld,
    input  logic [N-1:0]  data_in,
    input  logic          ser_in,
    input  logic          start,
    input  logic [2:0]    mode,
    input  logic [AW-1:0] amount,
    output logic [N-1:0]  data_out,
    output logic          busy,
    output logic          done
`ifdef SEQ_SHIFTER_CARRY_EN
    ,
    output logic          c_out
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0] MODE_LSL = 3'b000;
    localparam logic [2:0] MODE_LSR = 3'b001;
    localparam logic [2:0] MODE_ASR = 3'b010;
    localparam logic [2:0] MODE_ROL = 3'b011;
    localparam logic [2:0] MODE_ROR = 3'b100;

    state_t        state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic [2:0]    mode_q, mode_nxt;
    logic [N-1:0]  shreg, shreg_nxt;
    logic [N-1:0]  step_val;

    // One step of the latched operation; reserved modes leave the value alone.
    always_comb begin
        step_val = shreg;
        case (mode_q)
            MODE_LSL: step_val = {shreg[N-2:0], ser_in};
            MODE_LSR: step_val = {ser_in, shreg[N-1:1]};
            MODE_ASR: step_val = {shreg[N-1], shreg[N-1:1]};
            MODE_ROL: step_val = {shreg[N-2:0], shreg[N-1]};
            MODE_ROR: step_val = {shreg[0], shreg[N-1:1]};
            default:  step_val = shreg;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mode_nxt  = mode_q;
        shreg_nxt = shreg;
        case (state)
            IDLE: begin
                if (ld) begin
                    shreg_nxt = data_in;
                end else if (start) begin
                    mode_nxt  = mode;
                    cnt_nxt   = amount;
                    state_nxt = (amount == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                shreg_nxt = step_val;
                cnt_nxt   = cnt - {{(AW-1){1'b0}}, 1'b1};
                if (cnt == {{(AW-1){1'b0}}, 1'b1}) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            mode_q <= '0;
            shreg  <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            mode_q <= mode_nxt;
            shreg  <= shreg_nxt;
        end
    end

    assign data_out = shreg;
    assign busy     = (state == SHIFT);
    assign done     = (state == DONE);

`ifdef SEQ_SHIFTER_CARRY_EN
    logic step_out;
    logic step_vld;

    always_comb begin
        step_out = 1'b0;
        step_vld = 1'b1;
        case (mode_q)
            MODE_LSL, MODE_ROL: step_out = shreg[N-1];
            MODE_LSR, MODE_ASR, MODE_ROR: step_out = shreg[0];
            default: step_vld = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_out <= 1'b0;
        end else if (state == IDLE && ld) begin
            c_out <= 1'b0;
        end else if (state == SHIFT && step_vld) begin
            c_out <= step_out;
        end
    end
`endif

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter: expected results queued at start, checked when done pulses.
module tb_seq_shifter;
    localparam int N  = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld;
    logic [N-1:0]  data_in;
    logic          ser_in;
    logic          start;
    logic [2:0]    mode;
    logic [AW-1:0] amount;
    logic [N-1:0]  data_out;
    logic          busy;
    logic          done;
`ifdef SEQ_SHIFTER_CARRY_EN
    logic          c_out;
`endif

    seq_shifter #(.N(N), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .ld       (ld),
        .data_in  (data_in),
        .ser_in   (ser_in),
        .start    (start),
        .mode     (mode),
        .amount   (amount),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
`ifdef SEQ_SHIFTER_CARRY_EN
        ,
        .c_out    (c_out)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] d;
        logic         c;
        int           dcyc;
        int           nbusy;
    } exp_t;

    exp_t         sb[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    int           busy_run = 0;
    logic         prev_done = 1'b0;
    logic [N-1:0] m_reg = '0;
    logic         m_c   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    exp_t e;
    always @(negedge clk) begin
        if (!rst) busy_run = 0;
        else if (busy) busy_run++;
        if (prev_done && done) chk("done_width", done, 1'b0);
        if (done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", done, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("data", data_out, e.d);
                chk("done_cyc", cyc, e.dcyc);
                chk("busy_cycles", busy_run, e.nbusy);
                chk("busy_in_done", busy, 1'b0);
`ifdef SEQ_SHIFTER_CARRY_EN
                chk("carry", c_out, e.c);
`endif
            end
            busy_run = 0;
        end
        prev_done = done;
    end

    // Reference step written with plain shift operators.
    task automatic model_step(input logic [2:0] md, input logic s);
        case (md)
            3'd0: begin m_c = m_reg[N-1]; m_reg = (m_reg << 1) | {{(N-1){1'b0}}, s}; end
            3'd1: begin m_c = m_reg[0]; m_reg = m_reg >> 1; m_reg[N-1] = s; end
            3'd2: begin m_c = m_reg[0]; m_reg = m_reg >> 1; m_reg[N-1] = m_reg[N-2]; end
            3'd3: begin m_c = m_reg[N-1]; m_reg = (m_reg << 1) | (m_reg >> (N-1)); end
            3'd4: begin m_c = m_reg[0]; m_reg = (m_reg >> 1) | (m_reg << (N-1)); end
            default: ;
        endcase
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic do_ld(input logic [N-1:0] v);
        ld = 1'b1;
        data_in = v;
        tick();
        ld = 1'b0;
        m_reg = v;
        m_c = 1'b0;
        chk("ld_data", data_out, v);
    endtask

    task automatic do_op(input logic [2:0] md, input logic [AW-1:0] amt, input logic s, input bit push);
        exp_t x;
        ser_in = s;
        start  = 1'b1;
        mode   = md;
        amount = amt;
        for (int i = 0; i < int'(amt); i++) model_step(md, s);
        x.d = m_reg;
        x.c = m_c;
        x.dcyc = cyc + int'(amt) + 1;
        x.nbusy = int'(amt);
        if (push) sb.push_back(x);
        tick();
        start  = 1'b0;
        mode   = 3'($urandom);
        amount = AW'($urandom);
    endtask

    task automatic drain;
        for (int i = 0; i < 40 && (sb.size() != 0 || busy || done); i++) tick();
        chk("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; ld = 1'b0; data_in = '0; ser_in = 1'b0;
        start = 1'b0; mode = '0; amount = '0;
        #1;
        chk("rst_data", data_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
`ifdef SEQ_SHIFTER_CARRY_EN
        chk("rst_carry", c_out, 0);
`endif
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        do_ld(8'h5A);

        do_ld(8'hB5);
        do_op(3'b000, 3, 1'b0, 1'b1);
        drain();
        chk("lsl_b5", data_out, 8'hA8);
`ifdef SEQ_SHIFTER_CARRY_EN
        chk("lsl_b5_c", c_out, 1);
`endif

        do_ld(8'h81);
        do_op(3'b010, 2, 1'b0, 1'b1);
        drain();
        chk("asr_81", data_out, 8'hE0);
`ifdef SEQ_SHIFTER_CARRY_EN
        chk("asr_81_c", c_out, 0);
`endif

        do_ld(8'h81);
        do_op(3'b100, 1, 1'b0, 1'b1);
        drain();
        chk("ror_81", data_out, 8'hC0);
`ifdef SEQ_SHIFTER_CARRY_EN
        chk("ror_81_c", c_out, 1);
`endif
        do_op(3'b011, 0, 1'b0, 1'b1);
        drain();
        chk("amt0_hold", data_out, 8'hC0);

        do_ld(8'h0F);
        do_op(3'b001, 4, 1'b1, 1'b1);
        start = 1'b1; ld = 1'b1; data_in = 8'h00;
        tick();
        start = 1'b0; ld = 1'b0;
        drain();
        chk("lsr_0f", data_out, 8'hF0);

        do_ld(8'h42);
        do_op(3'b010, 7, 1'b0, 1'b1);
        drain();
        do_ld(8'h81);
        do_op(3'b011, 7, 1'b0, 1'b1);
        drain();
        do_ld(8'h3C);
        do_op(3'b101, 3, 1'b1, 1'b1);
        drain();
        chk("reserved_hold", data_out, 8'h3C);
        do_op(3'b000, 2, 1'b1, 1'b1);
        drain();

        for (int k = 0; k < 8; k++) begin
            do_ld(N'($urandom));
            do_op(3'($urandom_range(0, 7)), AW'($urandom), 1'($urandom), 1'b1);
            drain();
        end

        do_ld(8'hFF);
        do_op(3'b000, 7, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk("abort_data", data_out, 0);
        chk("abort_busy", busy, 0);
`ifdef SEQ_SHIFTER_CARRY_EN
        chk("abort_carry", c_out, 0);
`endif
        m_reg = '0; m_c = 1'b0;
        tick();
        rst = 1'b1;
        repeat (10) tick();
        chk("abort_no_done", done, 0);

        ld = 1'b1; data_in = 8'h3C; start = 1'b1; mode = 3'b000; amount = 3;
        tick();
        ld = 1'b0; start = 1'b0;
        chk("ld_win_data", data_out, 8'h3C);
        chk("ld_win_busy", busy, 0);
        tick();
        chk("ld_win_busy2", busy, 0);
        chk("ld_win_done", done, 0);
        repeat (5) tick();
        chk("ld_win_hold", data_out, 8'h3C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 Parameter N, default 8: data register width in bits, N >= 2.
REQ-002 Parameter AW, default 3: shift-amount width in bits; maximum amount is 2^AW-1.
REQ-003 clk  input  1  single clock; all flops on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 ld  input  1  parallel load request, honoured only in IDLE.
REQ-006 data_in  input  N  parallel load value.
REQ-007 ser_in  input  1  serial fill bit for logical shifts, sampled live every SHIFT cycle.
REQ-008 start  input  1  operation request, honoured only in IDLE.
REQ-009 mode  input  3  operation select, latched at start.
REQ-010 amount  input  AW  number of 1-bit steps, latched at start.
REQ-011 data_out  output  N  current register contents.
REQ-012 busy  output  1  high while in SHIFT.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 c_out  output  1  last bit shifted or rotated out; present only under the configuration macro (REQ-032).

Function
REQ-015 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-016 In IDLE, ld=1 SHALL load data_in into the register in one cycle, clear c_out and stay in IDLE.
REQ-017 In IDLE with ld=0, start=1 SHALL latch mode and amount; amount>0 goes to SHIFT, amount=0 goes straight to DONE with the register unchanged.
REQ-018 If ld and start are both high in IDLE, ld SHALL win and start SHALL be ignored.
REQ-019 In SHIFT, each cycle SHALL perform one 1-bit step per the latched mode and decrement the step counter.
REQ-020 The FSM SHALL move SHIFT->DONE on the cycle that performs the last step, so busy is high for exactly amount cycles.
REQ-021 In DONE, done SHALL be 1 and busy 0 for one cycle, then the FSM SHALL return to IDLE; start and ld are ignored in DONE.
REQ-022 Mode 000, logical left: LSB filled with ser_in; MSB shifted out.
REQ-023 Mode 001, logical right: MSB filled with ser_in; LSB shifted out.
REQ-024 Mode 010, arithmetic right: MSB replicated; LSB shifted out.
REQ-025 Mode 011, rotate left: MSB wraps into LSB and is also the out bit.
REQ-026 Mode 100, rotate right: LSB wraps into MSB and is also the out bit.
REQ-027 Modes 101-111 are reserved: the register SHALL hold its value, the counter SHALL still run amount cycles, done SHALL pulse as normal, and c_out SHALL be unchanged.
REQ-028 start, ld, mode and amount SHALL be ignored while busy; changes to mode or amount after start SHALL have no effect.
REQ-029 data_out SHALL be a direct register output with no combinational path from any input.

Reset
REQ-030 rst=0 SHALL asynchronously force state IDLE, register 0, counter 0, busy 0, done 0 and c_out 0, including mid-SHIFT; any in-flight operation is aborted with no done pulse.
REQ-031 After rst returns high, the block SHALL accept ld or start on the first rising clock edge.

Configuration
REQ-032 Macro SEQ_SHIFTER_CARRY_EN: when defined, c_out is a flop updated with the out bit on every SHIFT step (non-reserved modes) and cleared on ld; when undefined, no carry flop is built and the c_out port does not exist.

Verification
REQ-033 N=8: ld 0xB5; start mode=000 amount=3 ser_in=0 -> busy 3 cycles, done on 4th cycle, data_out=0xA8, c_out=1.
REQ-034 ld 0x81; start mode=010 amount=2 -> data_out=0xE0, c_out=0, done one cycle after busy falls.
REQ-035 ld 0x81; start mode=100 amount=1 -> data_out=0xC0, c_out=1; separately, start amount=0 -> busy never high, done next cycle, data unchanged.
REQ-036 ld 0x0F; start mode=001 amount=4 ser_in=1; during SHIFT pulse start and ld with data_in=0x00 -> both ignored; data_out=0xF0.
REQ-037 ld 0xFF; start mode=000 amount=7; drive rst low at SHIFT cycle 2 -> data_out=0x00, busy=0, c_out=0, no done pulse.
REQ-038 Same cycle ld=1 with data_in=0x3C and start=1 -> register=0x3C, FSM stays IDLE, no done pulse.
